// File: rtl/axi_rd_master_pkg.sv
// Shared AXI constants and a compile-time log2 helper for the DDR read master.
package axi_rd_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // Smallest n with 2**n >= value; used for ARSIZE and the length-queue depth.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// AXI3 read-address and read-data channels between the NPU read master and DDR.
interface axi_rd_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 6
);

  logic [ID_WIDTH-1:0]   M_AXI_ARID;
  logic [31:0]           M_AXI_ARADDR;
  logic [3:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic [1:0]            M_AXI_ARLOCK;
  logic [3:0]            M_AXI_ARCACHE;
  logic [2:0]            M_AXI_ARPROT;
  logic [3:0]            M_AXI_ARQOS;
  logic [0:0]            M_AXI_ARUSER;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ID_WIDTH-1:0]   M_AXI_RID;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
           M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
           M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RVALID
  );

endinterface

// File: rtl/axi_rd_master_fifo.sv
// Small synchronous FIFO holding ARLEN of each burst that is still awaiting RLAST.
module axi_rd_master_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_full   = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr];

  // Pointer, occupancy and storage update; overflowing pushes and empty pops are ignored.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + ADDR_WIDTH'(1);
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
      if (w_doPush && !w_doPop)      r_count <= r_count + (ADDR_WIDTH+1)'(1);
      else if (!w_doPush && w_doPop) r_count <= r_count - (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI3 read master: splits one beat-count request into 4KB-safe INCR bursts and
// streams the returning R beats straight into the NPU input buffer.
module axi_rd_master
  import axi_rd_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH      = 64,
  parameter int C_M_AXI_THREAD_ID_WIDTH = 6,
  parameter int C_M_AXI_RD_BURST_LEN    = 16,
  parameter int TX_SIZE_WIDTH           = 10,
  parameter int MAX_OUTSTANDING         = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          rx_req,
  input  logic [31:0]                   rx_addr,
  input  logic [TX_SIZE_WIDTH-1:0]      rx_req_size,
  output logic                          rx_done,
  output logic                          rd_busy,
  output logic                          rd_error,
  axi_rd_master_if.master               m_axi,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_to_inBuf,
  output logic                          inBuf_push,
  input  logic                          inBuf_full
);

  localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SIZE_LOG2  = clog2(BEAT_BYTES);
  localparam int FIFO_AW    = clog2(MAX_OUTSTANDING);
  localparam int OW         = FIFO_AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               r_state;
  logic [31:0]              r_addr;
  logic [TX_SIZE_WIDTH-1:0] r_remaining;
  logic [OW-1:0]            r_outstanding;
  logic [3:0]               r_beatCnt;
  logic                     r_rxDone;
  logic                     r_rdError;
  logic                     r_outEn;

  logic [12:0]   w_pageBeats;
  logic [4:0]    w_len;
  logic [3:0]    w_arLen;
  logic          w_arValid;
  logic          w_arHs;
  logic          w_lastBurst;
  logic          w_reqAccept;
  logic          w_rHs;
  logic          w_burstClose;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic [3:0]    w_headLen;
  logic [OW-1:0] w_outNext;

  assign w_pageBeats = (13'h1000 - {1'b0, r_addr[11:0]}) >> SIZE_LOG2;
  assign w_arLen     = 4'(w_len - 5'd1);
  assign w_arValid   = (r_state == S_ISSUE) && (r_outstanding < OW'(MAX_OUTSTANDING)) && !w_fifoFull;
  assign w_arHs      = w_arValid && m_axi.M_AXI_ARREADY;
  assign w_lastBurst = (r_remaining == TX_SIZE_WIDTH'(w_len));
  assign w_reqAccept = (r_state == S_IDLE) && rx_req;
  assign w_rHs       = m_axi.M_AXI_RVALID && m_axi.M_AXI_RREADY;
  assign w_burstClose = w_rHs && m_axi.M_AXI_RLAST && !w_fifoEmpty;

  assign m_axi.M_AXI_ARID    = '0;
  assign m_axi.M_AXI_ARADDR  = (r_state == S_ISSUE) ? r_addr : 32'd0;
  assign m_axi.M_AXI_ARLEN   = (r_state == S_ISSUE) ? w_arLen : 4'd0;
  assign m_axi.M_AXI_ARSIZE  = 3'(SIZE_LOG2);
  assign m_axi.M_AXI_ARBURST = AXI_BURST_INCR;
  assign m_axi.M_AXI_ARLOCK  = 2'b00;
  assign m_axi.M_AXI_ARCACHE = AXI_CACHE_DEFAULT;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARQOS   = 4'b0000;
  assign m_axi.M_AXI_ARUSER  = 1'b0;
  assign m_axi.M_AXI_ARVALID = w_arValid;
  assign m_axi.M_AXI_RREADY  = r_outEn && !inBuf_full;

  assign data_to_inBuf = r_outEn ? m_axi.M_AXI_RDATA : '0;
  assign inBuf_push    = w_rHs;
  assign rx_done       = r_rxDone;
  assign rd_busy       = (r_state != S_IDLE);
  assign rd_error      = r_rdError;

  // Burst length is the tightest of remaining beats, max burst and beats left in the 4KB page.
  always_comb begin
    w_len = 5'(C_M_AXI_RD_BURST_LEN);
    if (32'(r_remaining) < 32'(w_len)) w_len = 5'(r_remaining);
    if (32'(w_pageBeats) < 32'(w_len)) w_len = 5'(w_pageBeats);
  end

  // Outstanding-burst count after this cycle's AR issue and RLAST retirement.
  always_comb begin
    w_outNext = r_outstanding;
    if (w_arHs && !w_burstClose)      w_outNext = r_outstanding + OW'(1);
    else if (!w_arHs && w_burstClose) w_outNext = r_outstanding - OW'(1);
  end

  // AR issue FSM: latch the request, walk the address per burst, then wait for all RLASTs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_rxDone      <= 1'b0;
      r_outEn       <= 1'b0;
    end else begin
      r_outEn       <= 1'b1;
      r_rxDone      <= 1'b0;
      r_outstanding <= w_outNext;
      case (r_state)
        S_IDLE: begin
          if (rx_req) begin
            r_addr      <= rx_addr & ~32'(BEAT_BYTES - 1);
            r_remaining <= rx_req_size;
            if (rx_req_size == '0) r_rxDone <= 1'b1;
            else                   r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_arHs) begin
            r_addr      <= r_addr + (32'(w_len) << SIZE_LOG2);
            r_remaining <= r_remaining - TX_SIZE_WIDTH'(w_len);
            if (w_lastBurst) begin
              r_state  <= S_DRAIN;
              r_rxDone <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_outNext == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // R-path beat tracking against the expected burst length, with sticky protocol/response errors.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_beatCnt <= '0;
      r_rdError <= 1'b0;
    end else begin
      if (w_reqAccept) r_rdError <= 1'b0;
      if (w_rHs) begin
        if (w_fifoEmpty) begin
          r_rdError <= 1'b1;
        end else begin
          if ((m_axi.M_AXI_RRESP != AXI_RESP_OKAY) ||
              (m_axi.M_AXI_RLAST != (r_beatCnt == w_headLen))) r_rdError <= 1'b1;
          if (m_axi.M_AXI_RLAST) r_beatCnt <= '0;
          else                   r_beatCnt <= r_beatCnt + 4'd1;
        end
      end
    end
  end

  axi_rd_master_fifo #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (FIFO_AW)
  ) u_lenFifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .i_push  (w_arHs),
    .i_data  (w_arLen),
    .i_pop   (w_burstClose),
    .o_data  (w_headLen),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: a DDR slave model answers ARs, and a single
// monitor scores every AR, inBuf push and rx_done against queued expectations.
module tb_axi_rd_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        rxReq;
  logic [31:0] rxAddr;
  logic [9:0]  rxSize;
  logic        rxDone;
  logic        rdBusy;
  logic        rdError;
  logic [63:0] dataToInBuf;
  logic        inBufPush;
  logic        inBufFull;

  int checks = 0;
  int errors = 0;
  int arCount = 0;
  int pushCount = 0;

  burst_t      expArQ[$];
  logic [63:0] expDataQ[$];
  int          expDoneQ[$];

  burst_t slvQ[$];
  int     beatIdx = 0;
  bit     arReadyEn = 1'b1;
  bit     rHold = 1'b0;
  int     errBeat = -1;
  int     earlyLastBeat = -1;

  axi_rd_master_if #(.DATA_WIDTH(64), .ID_WIDTH(6)) axi ();

  axi_rd_master dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .rx_req        (rxReq),
    .rx_addr       (rxAddr),
    .rx_req_size   (rxSize),
    .rx_done       (rxDone),
    .rd_busy       (rdBusy),
    .rd_error      (rdError),
    .m_axi         (axi),
    .data_to_inBuf (dataToInBuf),
    .inBuf_push    (inBufPush),
    .inBuf_full    (inBufFull)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [63:0] dataOf(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic expectAr(input logic [31:0] addr, input logic [3:0] len);
    burst_t b;
    b.addr = addr;
    b.len  = len;
    expArQ.push_back(b);
  endtask

  task automatic expectBeats(input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) expDataQ.push_back(dataOf(addr + 32'(i * 8)));
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [9:0] size, input int nAr);
    expDoneQ.push_back(arCount + nAr);
    @(posedge ACLK); #1;
    rxReq  = 1'b1;
    rxAddr = addr;
    rxSize = size;
    @(posedge ACLK); #1;
    rxReq  = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < 4000) begin
      @(posedge ACLK); #2;
      n++;
      pending = rdBusy || (expArQ.size() != 0) || (expDataQ.size() != 0) || (expDoneQ.size() != 0);
    end
    if (pending) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual busy=%0b ars_left=%0d beats_left=%0d dones_left=%0d required all zero",
               name, rdBusy, expArQ.size(), expDataQ.size(), expDoneQ.size());
      expArQ.delete();
      expDataQ.delete();
      expDoneQ.delete();
    end
  endtask

  // Scoreboard monitor: compares every DUT-presented AR, inBuf push and rx_done pulse.
  always @(negedge ACLK) begin
    burst_t e;
    if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
      arCount++;
      if (expArQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ar_unexpected actual addr=%h len=%0d required none", axi.M_AXI_ARADDR, axi.M_AXI_ARLEN);
      end else begin
        e = expArQ.pop_front();
        checkOutput("ar_addr_len_size_burst",
                    64'({axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST}),
                    64'({e.addr, e.len, 3'd3, 2'b01}));
      end
    end
    if (inBufPush) begin
      pushCount++;
      if (expDataQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL push_unexpected actual data=%h required none", dataToInBuf);
      end else begin
        checkOutput("inbuf_data", dataToInBuf, expDataQ.pop_front());
      end
    end
    if (rxDone) begin
      if (expDoneQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_unexpected actual rx_done=1 required 0");
      end else begin
        checkOutput("done_after_ar_count", 64'(arCount), 64'(expDoneQ.pop_front()));
      end
    end
  end

  // DDR slave model: queues accepted ARs and returns their beats in order.
  initial begin
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RLAST   = 1'b0;
    axi.M_AXI_RRESP   = 2'b00;
    axi.M_AXI_RDATA   = '0;
    axi.M_AXI_RID     = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        slvQ.delete();
        beatIdx = 0;
      end else begin
        if (axi.M_AXI_RVALID && axi.M_AXI_RREADY && slvQ.size() > 0) begin
          if (axi.M_AXI_RLAST) begin
            slvQ.delete(0);
            beatIdx = 0;
            errBeat = -1;
            earlyLastBeat = -1;
          end else begin
            beatIdx++;
          end
        end
        if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
          burst_t b;
          b.addr = axi.M_AXI_ARADDR;
          b.len  = axi.M_AXI_ARLEN;
          slvQ.push_back(b);
        end
      end
      @(posedge ACLK); #1;
      axi.M_AXI_ARREADY = arReadyEn;
      if (ARESETN && !rHold && slvQ.size() > 0) begin
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = dataOf(slvQ[0].addr + 32'(beatIdx * 8));
        axi.M_AXI_RLAST  = (beatIdx == int'(slvQ[0].len)) || (beatIdx == earlyLastBeat);
        axi.M_AXI_RRESP  = (beatIdx == errBeat) ? 2'b10 : 2'b00;
      end else begin
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RLAST  = 1'b0;
        axi.M_AXI_RRESP  = 2'b00;
      end
    end
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int base;
    ARESETN   = 1'b0;
    rxReq     = 1'b0;
    rxAddr    = '0;
    rxSize    = '0;
    inBufFull = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset_ctrl", 64'({rxDone, rdBusy, rdError, axi.M_AXI_ARVALID, axi.M_AXI_RREADY, inBufPush}), 64'd0);
    checkOutput("reset_ar", 64'({axi.M_AXI_ARADDR, axi.M_AXI_ARLEN}), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);

    $display("[TB] test 1: two full bursts from 0x1000");
    expectAr(32'h1000, 4'd15);
    expectAr(32'h1080, 4'd15);
    expectBeats(32'h1000, 32);
    applyStimulus(32'h1000, 10'd32, 2);
    waitIdle("t1");
    checkOutput("t1_rd_error", 64'(rdError), 64'd0);

    $display("[TB] test 2: 4KB boundary split");
    expectAr(32'h0FC0, 4'd7);
    expectAr(32'h1000, 4'd7);
    expectBeats(32'h0FC0, 16);
    applyStimulus(32'h0FC0, 10'd16, 2);
    waitIdle("t2");

    $display("[TB] test 3: short burst with ARREADY stall, unaligned address, zero size");
    arReadyEn = 1'b0;
    expectAr(32'h3000, 4'd4);
    expectBeats(32'h3000, 5);
    applyStimulus(32'h3005, 10'd5, 1);
    repeat (3) begin @(posedge ACLK); #2; end
    checkOutput("t3_ar_held", 64'({axi.M_AXI_ARVALID, axi.M_AXI_ARADDR, axi.M_AXI_ARLEN}), 64'({1'b1, 32'h3000, 4'd4}));
    arReadyEn = 1'b1;
    waitIdle("t3");
    applyStimulus(32'h3100, 10'd0, 0);
    checkOutput("t3_zero_done_next", 64'({rxDone, axi.M_AXI_ARVALID, rdBusy}), 64'({1'b1, 1'b0, 1'b0}));
    waitIdle("t3_zero");

    $display("[TB] test 4: outstanding cap and inBuf back-pressure");
    base = arCount;
    rHold = 1'b1;
    for (int k = 0; k < 8; k++) expectAr(32'h2000 + 32'(k * 128), 4'd15);
    expectBeats(32'h2000, 128);
    applyStimulus(32'h2000, 10'd128, 8);
    repeat (20) begin @(posedge ACLK); #2; end
    checkOutput("t4_ar_cap", 64'({arCount - base, 31'(axi.M_AXI_ARVALID)}), 64'({32'd4, 31'd0}));
    inBufFull = 1'b1;
    rHold = 1'b0;
    base = pushCount;
    for (int k = 0; k < 10; k++) begin
      @(posedge ACLK); #2;
      checkOutput("t4_backpressure", 64'({axi.M_AXI_RREADY, inBufPush, 32'(pushCount - base)}), 64'd0);
    end
    inBufFull = 1'b0;
    waitIdle("t4");

    $display("[TB] test 5: bad RRESP then early RLAST");
    errBeat = 2;
    expectAr(32'h4000, 4'd15);
    expectBeats(32'h4000, 16);
    applyStimulus(32'h4000, 10'd16, 1);
    waitIdle("t5a");
    checkOutput("t5_rresp_sticky", 64'(rdError), 64'd1);
    earlyLastBeat = 7;
    expectAr(32'h5000, 4'd15);
    expectBeats(32'h5000, 8);
    applyStimulus(32'h5000, 10'd16, 1);
    checkOutput("t5_error_cleared", 64'(rdError), 64'd0);
    waitIdle("t5b");
    checkOutput("t5_early_rlast", 64'(rdError), 64'd1);

    $display("[TB] test 6: reset mid-request then clean request");
    for (int k = 0; k < 4; k++) expectAr(32'h6000 + 32'(k * 128), 4'd15);
    expectBeats(32'h6000, 64);
    base = pushCount;
    applyStimulus(32'h6000, 10'd64, 4);
    for (int k = 0; k < 200 && pushCount < base + 5; k++) begin @(posedge ACLK); #2; end
    checkOutput("t6_midburst_busy", 64'(rdBusy), 64'd1);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    #1;
    checkOutput("t6_reset_ctrl", 64'({rxDone, rdBusy, rdError, axi.M_AXI_ARVALID, axi.M_AXI_RREADY, inBufPush}), 64'd0);
    checkOutput("t6_reset_data", dataToInBuf | 64'({axi.M_AXI_ARADDR, axi.M_AXI_ARLEN}), 64'd0);
    expArQ.delete();
    expDataQ.delete();
    expDoneQ.delete();
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    expectAr(32'h7000, 4'd15);
    expectAr(32'h7080, 4'd3);
    expectBeats(32'h7000, 20);
    applyStimulus(32'h7000, 10'd20, 2);
    waitIdle("t6");
    checkOutput("t6_rd_error", 64'(rdError), 64'd0);

    repeat (5) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
